// File: rtl/ama_riscv_defines.sv
// Shared core definitions: branch funct3 encodings, branch-resolve FSM
// state encoding and small branch-decode helpers.
package ama_riscv_defines;

  // RISC-V conditional branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Branch-resolve FSM state encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_FLUSH = 1'b1;

  // 010/011 are not branch encodings
  function automatic logic br_legal(input logic [2:0] funct3);
    return (funct3[2:1] != 2'b01);
  endfunction

  // Branch outcome from compare-unit flags; illegal encodings never take
  function automatic logic br_taken(input logic [2:0] funct3,
                                    input logic       eq,
                                    input logic       lt);
    logic t;
    t = 1'b0;
    case (funct3)
      F3_BEQ:           t = eq;
      F3_BNE:           t = !eq;
      F3_BLT, F3_BLTU:  t = lt;
      F3_BGE, F3_BGEU:  t = !lt;
      default:          t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ama_riscv_branch_resolve.sv
// EX-stage branch resolution: decides taken/not-taken from the external
// compare unit, requests a PC redirect and holds a front-end flush for
// FLUSH_CYCLES un-stalled cycles after every taken branch.
module ama_riscv_branch_resolve
  import ama_riscv_defines::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_valid,
  input  logic [2:0]  br_funct3,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        op_uns,
  input  logic        op_eq,
  input  logic        op_lt,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        illegal,
  output logic [31:0] cnt_branch,
  output logic [31:0] cnt_taken
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  logic        state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] redirect_pc_reg, redirect_pc_next;
  logic        illegal_reg, illegal_next;
  logic [31:0] cnt_branch_reg, cnt_branch_next;
  logic [31:0] cnt_taken_reg, cnt_taken_next;

  logic accept;
  logic legal;
  logic taken;

  // Signed/unsigned select follows funct3 directly so the compare unit
  // settles in the same cycle the branch is presented.
  assign op_uns = br_funct3[1];

  assign accept = (state_reg == ST_IDLE) && br_valid && !stall;
  assign legal  = br_legal(br_funct3);
  assign taken  = legal && br_taken(br_funct3, op_eq, op_lt);

  // Next-state, counter and statistics logic
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    redirect_pc_next = redirect_pc_reg;
    illegal_next     = 1'b0;
    cnt_branch_next  = cnt_branch_reg;
    cnt_taken_next   = cnt_taken_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          if (!legal) begin
            illegal_next = 1'b1;
          end else begin
            cnt_branch_next = cnt_branch_reg + 32'd1;
            if (taken) begin
              cnt_taken_next   = cnt_taken_reg + 32'd1;
              state_next       = ST_FLUSH;
              cnt_next         = FLUSH_LOAD;
              redirect_pc_next = br_target;
            end
          end
        end
      end
      default: begin
        // Branches arriving during the flush window are wrong-path and ignored
        if (!stall) begin
          cnt_next = cnt_reg - 3'd1;
          if (cnt_reg == 3'd1) begin
            state_next = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= 3'd0;
      redirect_pc_reg <= 32'd0;
      illegal_reg     <= 1'b0;
      cnt_branch_reg  <= 32'd0;
      cnt_taken_reg   <= 32'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      redirect_pc_reg <= redirect_pc_next;
      illegal_reg     <= illegal_next;
      cnt_branch_reg  <= cnt_branch_next;
      cnt_taken_reg   <= cnt_taken_next;
    end
  end

  // Redirect only in the first flush cycle; a stall holds the counter and
  // therefore holds redirect as well.
  assign flush       = (state_reg == ST_FLUSH);
  assign redirect    = (state_reg == ST_FLUSH) && (cnt_reg == FLUSH_LOAD);
  assign redirect_pc = redirect_pc_reg;
  assign illegal     = illegal_reg;
  assign cnt_branch  = cnt_branch_reg;
  assign cnt_taken   = cnt_taken_reg;

endmodule
